// File: rtl/dmem_responder.sv
// Data-memory responder: owns a word-organised synchronous RAM and services
// byte/halfword/word loads and stores from the MEM stage over a req/ack
// handshake. Sub-word stores are done as read-modify-write, and misaligned
// or illegal accesses are rejected with misalign=1 and have no memory effect.
module dmem_responder #(
    parameter int WORD_AW = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] adr,
    input  logic [31:0] rD2,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MERGE,
        RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t state, state_nx;

    logic [31:0]        mem [0:(1 << WORD_AW) - 1];
    logic [WORD_AW-1:0] idx_in;
    logic               accept;
    logic               acc_err;

    // Request fields latched at acceptance.
    logic [1:0]         size_q;
    logic               uns_q;
    logic [1:0]         lane_q;
    logic [WORD_AW-1:0] idx_q;
    logic [15:0]        wdata_q;
    logic               err_q;

    logic [31:0]        rd_q;
    logic               mem_we;
    logic               mem_re;
    logic [WORD_AW-1:0] mem_widx;
    logic [31:0]        mem_wdata;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        load_val;
    logic [31:0]        merged;

    // Upper address bits alias away; they are intentionally not decoded.
    logic unused_adr;
    assign unused_adr = ^adr[31:WORD_AW+2];

    assign idx_in  = adr[WORD_AW+1:2];
    // Gating with rst keeps a request presented during reset from touching the array.
    assign accept  = (state == IDLE) && req && !rst;
    assign acc_err = (size == 2'b11)
                   || ((size == SZ_HALF) && adr[0])
                   || ((size == SZ_WORD) && (adr[1:0] != 2'b00));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode and handshake outputs.
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        ack      = 1'b0;
        misalign = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (accept) begin
                    if (acc_err)                    state_nx = RESP;
                    else if (we && size == SZ_WORD) state_nx = RESP;
                    else if (we)                    state_nx = MERGE;
                    else                            state_nx = LOAD;
                end
            end
            LOAD:    state_nx = RESP;
            MERGE:   state_nx = RESP;
            RESP: begin
                ack      = 1'b1;
                misalign = err_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture the request fields at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            lane_q  <= 2'b00;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            size_q  <= size;
            uns_q   <= unsigned_ld;
            lane_q  <= adr[1:0];
            idx_q   <= idx_in;
            wdata_q <= rD2[15:0];
            err_q   <= acc_err;
        end
    end

    // Array port control: word stores write at acceptance, other valid
    // accesses read at acceptance, and sub-word stores write back in MERGE.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_widx  = idx_in;
        mem_wdata = rD2;
        if (accept && !acc_err) begin
            if (we && size == SZ_WORD) mem_we = 1'b1;
            else                       mem_re = 1'b1;
        end
        if (state == MERGE) begin
            mem_we    = 1'b1;
            mem_widx  = idx_q;
            mem_wdata = merged;
        end
    end

    // Synchronous RAM with registered read data.
    // NOTE: the array and its read register are deliberately not reset, so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
        if (mem_re) rd_q <= mem[idx_in];
    end

    // Little-endian lane selection, extension and sub-word merge.
    always_comb begin
        byte_sel = rd_q[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? rd_q[31:16] : rd_q[15:0];
        case (size_q)
            SZ_BYTE: load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_val = rd_q;
        endcase
        merged = rd_q;
        if (size_q == SZ_BYTE) merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
        else                   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end

    // Load result register: updated only when a load completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                rdata <= '0;
        else if (state == LOAD) rdata <= load_val;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed accesses with literal expectations,
// plus a cycle-based transaction model compared against the outputs every cycle.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] adr;
    logic [31:0] rD2;
    logic        ready;
    logic        ack;
    logic [31:0] rdata;
    logic        misalign;

    dmem_responder #(.WORD_AW(12)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size),
        .unsigned_ld(unsigned_ld), .adr(adr), .rD2(rD2),
        .ready(ready), .ack(ack), .rdata(rdata), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    localparam int WORDS = 1 << 12;

    logic [31:0] mm [int];
    int          cyc       = 0;
    int          ack_cyc   = -1;
    bit          ack_mis   = 1'b0;
    logic [31:0] exp_rdata = '0;
    bit          pend      = 1'b0;
    int          commit_cyc;
    bit          p_we;
    logic [1:0]  p_size;
    bit          p_uns;
    logic [31:0] p_adr;
    logic [31:0] p_data;
    bit          m_idle;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % WORDS);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input bit u, input logic [31:0] a);
        logic [31:0] v;
        if (sz == 2'd2) return w;
        if (sz == 2'd0) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (!u && v >= 32'd128) v = v - 32'd256;
        end else begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (!u && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        sh   = (sz == 2'd0) ? 8 * a[1:0] : 16 * a[1];
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_cyc   = -1;
            pend      = 1'b0;
            exp_rdata = '0;
        end else begin
            m_idle = (cyc > ack_cyc);
            cyc++;
            if (pend && cyc == commit_cyc) begin
                if (p_we) mm[widx(p_adr)] = model_merge(mm[widx(p_adr)], p_size, p_adr, p_data);
                else      exp_rdata = model_load(mm[widx(p_adr)], p_size, p_uns, p_adr);
                pend = 1'b0;
            end
            if (m_idle && req) begin
                if (size == 2'd3 || (size == 2'd1 && adr[0]) || (size == 2'd2 && adr[1:0] != 2'd0)) begin
                    ack_cyc = cyc;
                    ack_mis = 1'b1;
                end else if (we && size == 2'd2) begin
                    mm[widx(adr)] = rD2;
                    ack_cyc = cyc;
                    ack_mis = 1'b0;
                end else begin
                    pend       = 1'b1;
                    commit_cyc = cyc + 1;
                    ack_cyc    = cyc + 1;
                    ack_mis    = 1'b0;
                    p_we = we; p_size = size; p_uns = unsigned_ld; p_adr = adr; p_data = rD2;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'd0, ready}, {31'd0, cyc > ack_cyc});
            check("ack", {31'd0, ack}, {31'd0, cyc == ack_cyc});
            check("misalign", {31'd0, misalign}, {31'd0, (cyc == ack_cyc) && ack_mis});
            check("rdata", rdata, exp_rdata);
            if (ack === 1'b1) ack_cnt++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic mis, output logic [31:0] rd);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("ready_before_req", {31'd0, ready}, 32'd1);
        we = w; size = sz; unsigned_ld = u; adr = a; rD2 = d; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (ack !== 1'b1 && lat < 8) begin @(posedge clk); #1; lat++; end
        mis = misalign;
        rd  = rdata;
        @(posedge clk); #1;
    endtask

    task automatic do_ld(input string name, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] exp);
        int lat; logic mis; logic [31:0] rd;
        access(1'b0, sz, u, a, 32'd0, lat, mis, rd);
        check({name, "_lat"}, lat, 32'd2);
        check({name, "_mis"}, {31'd0, mis}, 32'd0);
        check({name, "_data"}, rd, exp);
    endtask

    task automatic do_st(input string name, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input int exp_lat);
        int lat; logic mis; logic [31:0] rd;
        access(1'b1, sz, 1'b0, a, d, lat, mis, rd);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_mis"}, {31'd0, mis}, 32'd0);
    endtask

    task automatic do_bad(input string name, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] exp_rd);
        int lat; logic mis; logic [31:0] rd;
        access(w, sz, 1'b0, a, 32'hFFFF_FFFF, lat, mis, rd);
        check({name, "_lat"}, lat, 32'd1);
        check({name, "_mis"}, {31'd0, mis}, 32'd1);
        check({name, "_rdata_kept"}, rd, exp_rd);
    endtask

    int a0;

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; unsigned_ld = 1'b0;
        adr = '0; rD2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Word store then load.
        do_st("sw_100", 2'd2, 32'h100, 32'hDEADBEEF, 1);
        do_ld("lw_100", 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);

        // Byte/half lanes and extension.
        do_ld("lb_103", 2'd0, 1'b0, 32'h103, 32'hFFFFFFDE);
        do_ld("lbu_101", 2'd0, 1'b1, 32'h101, 32'h000000BE);
        do_ld("lh_100", 2'd1, 1'b0, 32'h100, 32'hFFFFBEEF);
        do_ld("lhu_102", 2'd1, 1'b1, 32'h102, 32'h0000DEAD);
        do_ld("lw_uns_ignored", 2'd2, 1'b1, 32'h100, 32'hDEADBEEF);

        // Sub-word read-modify-write.
        do_st("sb_102", 2'd0, 32'h102, 32'h12345655, 2);
        do_ld("lw_after_sb", 2'd2, 1'b0, 32'h100, 32'hDE55BEEF);
        do_st("sh_100", 2'd1, 32'h100, 32'h0000A5A5, 2);
        do_ld("lw_after_sh", 2'd2, 1'b0, 32'h100, 32'hDE55A5A5);

        // Address aliasing modulo 2^14 bytes.
        do_ld("lw_alias", 2'd2, 1'b0, 32'h8000_4100, 32'hDE55A5A5);

        // Other patterns, including the top word of the array.
        do_st("sw_1fc", 2'd2, 32'h1FC, 32'h80000001, 1);
        do_ld("lb_1fc", 2'd0, 1'b0, 32'h1FC, 32'h00000001);
        do_ld("lh_1fe", 2'd1, 1'b0, 32'h1FE, 32'hFFFF8000);
        do_st("sw_top", 2'd2, 32'h3FFC, 32'h01234567, 1);
        do_ld("lbu_top", 2'd0, 1'b1, 32'h3FFF, 32'h00000001);
        do_ld("lh_top_alias", 2'd1, 1'b0, 32'h7FFE, 32'h00000123);
        do_ld("lw_100_again", 2'd2, 1'b0, 32'h100, 32'hDE55A5A5);

        // Rejected accesses: no memory effect, rdata untouched.
        do_bad("bad_lw_102", 1'b0, 2'd2, 32'h102, 32'hDE55A5A5);
        do_bad("bad_sh_101", 1'b1, 2'd1, 32'h101, 32'hDE55A5A5);
        do_bad("bad_size3", 1'b1, 2'd3, 32'h100, 32'hDE55A5A5);
        do_bad("bad_sw_103", 1'b1, 2'd2, 32'h103, 32'hDE55A5A5);
        do_ld("lw_after_bad", 2'd2, 1'b0, 32'h100, 32'hDE55A5A5);
        do_ld("lbu_after_bad", 2'd0, 1'b1, 32'h101, 32'h000000A5);

        // req held high for 9 edges from idle: accepted at edges 0, 3 and 6.
        a0 = ack_cnt;
        we = 1'b0; size = 2'd2; unsigned_ld = 1'b0; adr = 32'h1FC; req = 1'b1;
        repeat (9) @(posedge clk);
        #1 req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held_req_acks", ack_cnt - a0, 32'd3);
        check("held_req_rdata", rdata, 32'h80000001);

        // A store request raised while busy must be ignored.
        we = 1'b0; size = 2'd2; adr = 32'h100; req = 1'b1;
        @(posedge clk); #1;
        we = 1'b1; size = 2'd2; adr = 32'h100; rD2 = 32'h0; req = 1'b1;
        repeat (2) @(posedge clk);
        #1 req = 1'b0;
        check("busy_ignored_ready", {31'd0, ready}, 32'd1);
        do_ld("lw_after_ignored", 2'd2, 1'b0, 32'h100, 32'hDE55A5A5);

        // Reset in the MERGE-pending cycle of a byte store.
        a0 = ack_cnt;
        we = 1'b1; size = 2'd0; unsigned_ld = 1'b0; adr = 32'h100; rD2 = 32'h77; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_ack", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_ack", ack_cnt - a0, 32'd0);
        do_ld("lw_after_rst", 2'd2, 1'b0, 32'h100, 32'hDE55A5A5);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory access interface. It owns a word-organised synchronous data RAM and services load/store requests from the MEM stage over a req/ack handshake.
- Supports byte, halfword and word accesses, with sign or zero extension on loads and read-modify-write for sub-word stores.
- Flags misaligned or illegal accesses instead of performing them.
- Sits between the pipeline/multi-cycle MEM stage and the data RAM array.

Parameters:
- WORD_AW, 12, word-address width; the array holds 2^WORD_AW 32-bit words, indexed by adr[WORD_AW+1:2].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  access request; sampled only while ready=1.
- we  input  1  1=store, 0=load.
- size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- unsigned_ld  input  1  1=zero-extend sub-word load, 0=sign-extend.
- adr  input  32  byte address.
- rD2  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ready  output  1  responder idle and able to accept a request.
- ack  output  1  one-cycle completion pulse.
- rdata  output  32  extended load result.
- misalign  output  1  qualifies ack: access rejected, no memory effect.

Behaviour:
- Reset (async, rst=1): state=IDLE, ready=1, ack=0, misalign=0, rdata=0. The RAM contents are not reset.
- States: IDLE, LOAD, MERGE, RESP. ready=1 only in IDLE. ack=1 only in RESP.
- Acceptance: at a rising edge with state=IDLE and req=1, latch adr, we, size, unsigned_ld and rD2. req is ignored in every other state.
- Error check at acceptance; the access is an error if any of these holds:
  - size=11;
  - size=01 and adr[0]=1;
  - size=10 and adr[1:0]!=00.
  - On error: set the err flag and go to RESP. No array read or write takes place.
- Word store: the array word is written at the acceptance edge, then go to RESP. Latency: ack in the first cycle after acceptance.
- Load: the synchronous array read is issued at the acceptance edge, then go to LOAD.
  - At the LOAD edge, select the byte/half lane, extend it and register it into rdata, then go to RESP.
  - Latency: ack in the second cycle after acceptance. rdata is valid in the ack cycle.
- Sub-word store: the array read is issued at the acceptance edge, then go to MERGE.
  - At the MERGE edge, replace the addressed lane(s) of the read word with rD2[7:0] or rD2[15:0], write the merged word, then go to RESP.
  - Latency: 2 cycles, as for a load.
- Lane mapping is little-endian:
  - byte lane = adr[1:0], lane n is bits [8n+7:8n];
  - half lane = adr[1], upper half is bits [31:16].
- Extension: signed byte/half loads replicate bit 7/bit 15 into the upper bits; unsigned loads zero-fill. Word loads ignore unsigned_ld.
- RESP lasts exactly one cycle: ack=1, misalign=err. Then go to IDLE, so back-to-back requests have a minimum spacing of 2 cycles for word stores and errors, and 3 cycles otherwise.
- rdata holds its value until the next successful load completes. Stores and errors leave rdata unchanged.
- adr bits above WORD_AW+1 are ignored, so addresses alias modulo 2^(WORD_AW+2) bytes.
- Reset mid-operation:
  - A word store accepted before the reset edge has already been written.
  - A sub-word store reset before its MERGE edge writes nothing.
  - A pending ack is dropped.

Test Plan:
- Word store then load: store adr=0x100, rD2=0xDEADBEEF → ack 1 cycle after acceptance. Load word adr=0x100 → ack 2 cycles after acceptance, rdata=0xDEADBEEF, misalign=0.
- Byte lanes and extension: memory word 0x100 = 0xDEADBEEF.
  - Signed byte load adr=0x103 → rdata=0xFFFFFFDE.
  - Unsigned byte load adr=0x101 → rdata=0x000000BE.
  - Signed half load adr=0x100 → rdata=0xFFFFBEEF.
  - Unsigned half load adr=0x102 → rdata=0x0000DEAD.
- Sub-word store RMW: word 0x100 = 0xDEADBEEF; store byte adr=0x102, rD2=0x12345655 → word becomes 0xDE55BEEF. Store half adr=0x100, rD2=0x0000A5A5 → word becomes 0xDE55A5A5.
- Misalign: word load adr=0x102, half store adr=0x101, size=11 → each gives ack with misalign=1 one cycle after acceptance. Memory and rdata are unchanged; a follow-up word load adr=0x100 returns the prior value.
- Handshake: hold req=1 continuously for 10 cycles of word loads → ready drops after each acceptance and exactly one ack per accepted request is seen. req pulses while ready=0 are ignored.
- Reset: assert rst in the MERGE-pending cycle of a byte store to 0x100 → no write, ack never pulses, ready=1 and rdata=0 immediately. A later load shows the old value.
